output_flow_handler: RTL

Link-side transmit stage of a router output port, directly upstream of the neighbouring router's input flow handler. Buffers flits from the crossbar in a small FIFO and launches them onto the link only while downstream credits remain. Credits come back from the downstream receiver as a two-phase differential toggle pair, one toggle of both wires per credit. It maintains the credit counter and flags credit protocol violations.

---
 rtl/output_flow_handler.sv | 109 ++++++++++
 1 files changed

// File: rtl/output_flow_handler.sv
// Credit-gated link transmit stage: flit FIFO plus two-phase credit return.
// Define OUTPUT_FLOW_BYPASS_EN for same-cycle FIFO bypass when empty.
`timescale 1ns/1ps
module output_flow_handler #(
  parameter int FLIT_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic [FLIT_WIDTH-1:0] flit_din,
  input  logic                  flit_valid_din,
  output logic                  flit_ready_dout,
  input  logic                  diff_pair_p,
  input  logic                  diff_pair_n,
  output logic [FLIT_WIDTH-1:0] link_flit_dout,
  output logic                  link_valid_dout,
  output logic [CNT_WIDTH-1:0]  credit_count_dout,
  output logic                  error_dout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [CNT_WIDTH-1:0] CRED_C = CREDITS[CNT_WIDTH-1:0];

  logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_occ;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_p;
  logic                  r_n;
  logic                  r_err;
  logic                  r_lv;
  logic [FLIT_WIDTH-1:0] r_lflit;

  logic                  w_ret;
  logic                  w_push;
  logic                  w_has_cr;
  logic                  w_pop;
  logic                  w_send;
  logic                  w_wr;
  logic [FLIT_WIDTH-1:0] w_next_flit;

  // a credit is both wires differing from their trackers
  assign w_ret = (diff_pair_p ^ r_p) & (diff_pair_n ^ r_n);
  assign flit_ready_dout = rsta & (r_occ < DEPTH_C);
  assign w_push = flit_valid_din & flit_ready_dout;
  assign w_has_cr = (r_cnt != '0);
  assign w_pop = (r_occ != '0) & w_has_cr;

`ifdef OUTPUT_FLOW_BYPASS_EN
  logic w_byp;
  assign w_byp = w_push & (r_occ == '0) & w_has_cr;
  assign w_send = w_pop | w_byp;
  assign w_wr = w_push & ~w_byp;
  assign w_next_flit = w_byp ? flit_din : r_mem[r_rptr];
`else
  assign w_send = w_pop;
  assign w_wr = w_push;
  assign w_next_flit = r_mem[r_rptr];
`endif

  always_ff @(posedge clka) begin
    if (w_wr) r_mem[r_wptr] <= flit_din;
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_cnt   <= CRED_C;
      r_p     <= 1'b1;
      r_n     <= 1'b0;
      r_err   <= 1'b0;
      r_lv    <= 1'b0;
      r_lflit <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case (1'b1)
        w_wr & ~w_pop: r_occ <= r_occ + 1'b1;
        w_pop & ~w_wr: r_occ <= r_occ - 1'b1;
        default: ;
      endcase
      r_lv <= w_send;
      if (w_send) r_lflit <= w_next_flit;
      if (w_ret) begin
        r_p <= ~r_p;
        r_n <= ~r_n;
      end
      // a return with a full counter is dropped and flagged
      unique case (1'b1)
        w_ret & ~w_send: begin
          if (r_cnt == CRED_C) r_err <= 1'b1;
          else r_cnt <= r_cnt + 1'b1;
        end
        w_send & ~w_ret: r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign link_flit_dout    = r_lflit;
  assign link_valid_dout   = r_lv;
  assign credit_count_dout = r_cnt;
  assign error_dout        = r_err;
endmodule
